// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks one requester onto the UART TX FIFO for a whole
// message, releasing on the last byte or after an idle timeout.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [8*NREQ-1:0]    req_data_i,
    input  logic [NREQ-1:0]      req_last_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic                 uart_full_i,
    output logic                 uart_we_o,
    output logic [7:0]           uart_wdata_o,
    output logic [NREQ-1:0]      grant_o,
    output logic                 busy_o,
    output logic                 timeout_o,
    output logic [2:0]           timeout_id_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   owner_q;
    logic [NREQ-1:0] grant_q;
    logic [15:0]     idle_cnt_q;
    logic [15:0]     idle_cnt_d;
    logic            timeout_q;
    logic [2:0]      timeout_id_q;

    logic [IW-1:0]   arb_idx;
    logic            arb_found;
    int              scan;
    logic [7:0]      owner_data;
    logic            owner_valid;
    logic            owner_last;
    logic            locked;
    logic            xfer;
    logic            idle_inc;
    logic            timeout_hit;

    // Search starts one past the last owner so every requester gets its turn.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        scan      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            scan = (int'(ptr_q) + i) % NREQ;
            if (!arb_found && req_valid_i[scan[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = scan[IW-1:0];
            end
        end
    end

    always_comb begin
        owner_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner_q == IW'(k)) begin
                owner_data = req_data_i[8*k +: 8];
            end
        end
    end

    assign locked      = (state_q == ST_LOCKED);
    assign owner_valid = req_valid_i[owner_q];
    assign owner_last  = req_last_i[owner_q];
    assign xfer        = locked & ~uart_full_i & owner_valid;
    assign idle_inc    = locked & ~uart_full_i & ~owner_valid;
    assign idle_cnt_d  = idle_cnt_q + 16'd1;
    assign timeout_hit = idle_inc && (TIMEOUT != 0) && (idle_cnt_d == 16'(TIMEOUT));

    always_comb begin
        req_ready_o = '0;
        if (locked && !uart_full_i) begin
            req_ready_o[owner_q] = 1'b1;
        end
    end

    assign uart_we_o    = xfer;
    assign uart_wdata_o = xfer ? owner_data : 8'h00;
    assign grant_o      = grant_q;
    assign busy_o       = locked;
    assign timeout_o    = timeout_q;
    assign timeout_id_o = timeout_id_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            ptr_q        <= IW'(NREQ - 1);
            owner_q      <= '0;
            grant_q      <= '0;
            idle_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_found) begin
                        state_q    <= ST_LOCKED;
                        owner_q    <= arb_idx;
                        grant_q    <= {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
                        idle_cnt_q <= '0;
                    end
                end
                ST_LOCKED: begin
                    // A transfer always beats a timeout in the same cycle.
                    if (xfer) begin
                        idle_cnt_q <= '0;
                        if (owner_last) begin
                            state_q <= ST_IDLE;
                            ptr_q   <= owner_q;
                            grant_q <= '0;
                        end
                    end else if (timeout_hit) begin
                        state_q      <= ST_IDLE;
                        ptr_q        <= owner_q;
                        grant_q      <= '0;
                        idle_cnt_q   <= '0;
                        timeout_q    <= 1'b1;
                        timeout_id_q <= 3'(owner_q);
                    end else if (idle_inc) begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, TIMEOUT=10); inputs change and
// outputs are sampled around the falling clock edge.
module tb_uart_tx_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_last_i;
    logic [3:0]  req_ready_o;
    logic        uart_full_i;
    logic        uart_we_o;
    logic [7:0]  uart_wdata_o;
    logic [3:0]  grant_o;
    logic        busy_o;
    logic        timeout_o;
    logic [2:0]  timeout_id_o;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(.NREQ(4), .TIMEOUT(10)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_last_i   (req_last_i),
        .req_ready_o  (req_ready_o),
        .uart_full_i  (uart_full_i),
        .uart_we_o    (uart_we_o),
        .uart_wdata_o (uart_wdata_o),
        .grant_o      (grant_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o),
        .timeout_id_o (timeout_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".grant"}, 32'(grant_o), 0);
        chk({tag, ".busy"}, 32'(busy_o), 0);
        chk({tag, ".ready"}, 32'(req_ready_o), 0);
        chk({tag, ".we"}, 32'(uart_we_o), 0);
        chk({tag, ".wdata"}, 32'(uart_wdata_o), 0);
        chk({tag, ".timeout"}, 32'(timeout_o), 0);
        chk({tag, ".tid"}, 32'(timeout_id_o), 0);
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        uart_full_i = 1'b0;
        #1;
        chk_all_zero("reset");
        step();
        rst_i = 1'b0;

        // Single requester, two-byte message
        step();
        req_valid_i = 4'b0010; req_data_i[15:8] = 8'h41; req_last_i = 4'b0000;
        #1;
        chk("r1.idle_we", 32'(uart_we_o), 0);
        chk("r1.idle_ready", 32'(req_ready_o), 0);
        step(); #1;
        chk("r1.grant", 32'(grant_o), 32'h2);
        chk("r1.busy", 32'(busy_o), 1);
        chk("r1.ready", 32'(req_ready_o), 32'h2);
        chk("r1.we0", 32'(uart_we_o), 1);
        chk("r1.wd0", 32'(uart_wdata_o), 32'h41);
        step();
        req_data_i[15:8] = 8'h42; req_last_i = 4'b0010;
        #1;
        chk("r1.we1", 32'(uart_we_o), 1);
        chk("r1.wd1", 32'(uart_wdata_o), 32'h42);
        step();
        req_valid_i = '0; req_last_i = '0;
        #1;
        chk("r1.busy_drop", 32'(busy_o), 0);
        chk("r1.grant_drop", 32'(grant_o), 0);

        // Requesters 0 and 2 together after reset
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        req_valid_i = 4'b0101; req_data_i = 32'h00C0_00A0; req_last_i = 4'b0000;
        step(); #1;
        chk("r02.grant0", 32'(grant_o), 32'h1);
        chk("r02.wd_a0", 32'(uart_wdata_o), 32'hA0);
        step();
        req_data_i[7:0] = 8'hA1; req_last_i = 4'b0001;
        #1;
        chk("r02.wd_a1", 32'(uart_wdata_o), 32'hA1);
        chk("r02.ready_a1", 32'(req_ready_o), 32'h1);
        step();
        req_valid_i = 4'b0100; req_last_i = 4'b0000;
        #1;
        chk("r02.gap_busy", 32'(busy_o), 0);
        chk("r02.gap_we", 32'(uart_we_o), 0);
        step(); #1;
        chk("r02.grant2", 32'(grant_o), 32'h4);
        chk("r02.wd_c0", 32'(uart_wdata_o), 32'hC0);
        step();
        req_data_i[23:16] = 8'hC1; req_last_i = 4'b0100;
        #1;
        chk("r02.wd_c1", 32'(uart_wdata_o), 32'hC1);
        step();
        req_valid_i = '0; req_last_i = '0;
        #1;
        chk("r02.end_busy", 32'(busy_o), 0);

        // Requester 3 stalled by a full FIFO for 20 cycles
        req_valid_i = 4'b1000; req_data_i[31:24] = 8'hD3; req_last_i = 4'b1000;
        uart_full_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(); #1;
            chk("stall.ready", 32'(req_ready_o), 0);
            chk("stall.we", 32'(uart_we_o), 0);
            chk("stall.timeout", 32'(timeout_o), 0);
            chk("stall.busy", 32'(busy_o), 1);
        end
        step();
        uart_full_i = 1'b0;
        #1;
        chk("stall.ready_rel", 32'(req_ready_o), 32'h8);
        chk("stall.we_rel", 32'(uart_we_o), 1);
        chk("stall.wd_rel", 32'(uart_wdata_o), 32'hD3);
        step();
        req_valid_i = '0; req_last_i = '0;
        #1;
        chk("stall.end_busy", 32'(busy_o), 0);

        // Timeout: requester 2 goes quiet mid-message, requester 3 waits
        req_valid_i = 4'b0100; req_data_i[23:16] = 8'hE2; req_last_i = 4'b0000;
        step(); #1;
        chk("to.grant2", 32'(grant_o), 32'h4);
        chk("to.wd", 32'(uart_wdata_o), 32'hE2);
        step();
        req_valid_i = 4'b1000; req_data_i[31:24] = 8'hF3; req_last_i = 4'b1000;
        #1;
        for (int i = 1; i <= 10; i++) begin
            chk("to.wait_timeout", 32'(timeout_o), 0);
            chk("to.wait_busy", 32'(busy_o), 1);
            chk("to.wait_we", 32'(uart_we_o), 0);
            step(); #1;
        end
        chk("to.pulse", 32'(timeout_o), 1);
        chk("to.id", 32'(timeout_id_o), 2);
        chk("to.grant_drop", 32'(grant_o), 0);
        chk("to.busy_drop", 32'(busy_o), 0);
        step(); #1;
        chk("to.pulse_end", 32'(timeout_o), 0);
        chk("to.id_hold", 32'(timeout_id_o), 2);
        chk("to.grant3", 32'(grant_o), 32'h8);
        chk("to.wd3", 32'(uart_wdata_o), 32'hF3);
        step();
        req_valid_i = '0; req_last_i = '0;

        // Reset while requester 1 holds the lock mid-message
        req_valid_i = 4'b0010; req_data_i[15:8] = 8'h11; req_last_i = 4'b0000;
        step(); #1;
        chk("rst.grant1", 32'(grant_o), 32'h2);
        step();
        req_valid_i = '0;
        #1;
        chk("rst.held", 32'(busy_o), 1);
        #2;
        rst_i = 1'b1;
        req_valid_i = 4'b0011; req_data_i[7:0] = 8'h20; req_data_i[15:8] = 8'h12;
        req_last_i = 4'b0011;
        #1;
        chk_all_zero("rst.async");
        step();
        rst_i = 1'b0;
        step(); #1;
        chk("rst.first_grant", 32'(grant_o), 32'h1);
        chk("rst.wd0", 32'(uart_wdata_o), 32'h20);
        step();
        req_valid_i = 4'b0010;
        step(); #1;
        chk("rst.second_grant", 32'(grant_o), 32'h2);
        chk("rst.wd1", 32'(uart_wdata_o), 32'h12);
        step();
        req_valid_i = '0; req_last_i = '0;

        // All four request continuously with one-byte messages
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        req_valid_i = 4'b1111; req_last_i = 4'b1111; req_data_i = 32'h3332_3130;
        #1;
        chk("rr.first_idle_we", 32'(uart_we_o), 0);
        for (int m = 0; m < 8; m++) begin
            step(); #1;
            chk("rr.grant", 32'(grant_o), 32'(1 << (m % 4)));
            chk("rr.we", 32'(uart_we_o), 1);
            chk("rr.wd", 32'(uart_wdata_o), 32'(8'h30 + (m % 4)));
            step(); #1;
            chk("rr.gap_we", 32'(uart_we_o), 0);
        end
        req_valid_i = '0; req_last_i = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 255: idle-cycle limit for a locked requester; range 0..65535; 0 disables the timeout.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  input  NREQ  bit k: requester k presents a byte.
REQ-006 req_data_i  input  8*NREQ  requester k byte on bits [8k+7:8k].
REQ-007 req_last_i  input  NREQ  bit k: the presented byte ends requester k's message.
REQ-008 req_ready_o  output  NREQ  bit k: requester k's byte is accepted this cycle.
REQ-009 uart_full_i  input  1  UART TX FIFO full flag (backpressure).
REQ-010 uart_we_o  output  1  UART TX FIFO write enable.
REQ-011 uart_wdata_o  output  8  UART TX FIFO write data.
REQ-012 grant_o  output  NREQ  one-hot current owner; all-zero when no owner.
REQ-013 busy_o  output  1  high while a message is locked.
REQ-014 timeout_o  output  1  one-cycle pulse when a lock is force-released.
REQ-015 timeout_id_o  output  3  index of the last force-released requester; holds until the next timeout.

Function
REQ-016 The FSM has two states, IDLE and LOCKED; busy_o = (state == LOCKED).
REQ-017 The arbiter holds a round-robin pointer ptr (index of the last owner).
REQ-018 IDLE, any req_valid_i set: owner = first set bit searching ptr+1, ptr+2, ... modulo NREQ; next cycle is LOCKED with grant_o = onehot(owner).
REQ-019 IDLE: no byte transfers; req_ready_o = 0; uart_we_o = 0.
REQ-020 LOCKED: req_ready_o[g] = ~uart_full_i for owner g; every other ready bit is 0 (combinational).
REQ-021 Transfer = req_valid_i[g] & req_ready_o[g]; in that same cycle uart_we_o = 1 and uart_wdata_o = req_data_i[8g+7:8g] (combinational, zero-latency).
REQ-022 uart_we_o is never asserted while uart_full_i = 1.
REQ-023 When uart_we_o = 0, uart_wdata_o = 0.
REQ-024 Transfer with req_last_i[g] = 1: next cycle is IDLE, ptr <= g, grant_o <= 0.
REQ-025 Re-arbitration therefore costs exactly one IDLE cycle between messages; messages from different requesters never interleave.
REQ-026 Idle counter: 16-bit; cleared on entry to LOCKED and on every transfer.
REQ-027 Idle counter increments only in LOCKED cycles with req_valid_i[g] = 0 and uart_full_i = 0.
REQ-028 Cycles stalled by uart_full_i hold the idle counter and never cause a timeout.
REQ-029 TIMEOUT != 0 and the increment would make the counter equal to TIMEOUT: next cycle is IDLE, ptr <= g, grant_o <= 0, timeout_o pulses for one cycle, timeout_id_o <= g.
REQ-030 A transfer in the same cycle as the timeout condition wins: no timeout, and the counter clears.
REQ-031 Requester k may drop req_valid_i mid-message; the lock is kept and only the idle counter advances.
REQ-032 Fairness: a continuously requesting requester is granted within NREQ-1 other messages.

Reset
REQ-033 While rst_i is high, with no clock required: state = IDLE, ptr = NREQ-1 (requester 0 wins the first arbitration), idle counter = 0.
REQ-034 Reset values of outputs: grant_o = 0, busy_o = 0, req_ready_o = 0, uart_we_o = 0, uart_wdata_o = 0, timeout_o = 0, timeout_id_o = 0.
REQ-035 Reset asserted mid-message abandons the message; after release, arbitration restarts from requester 0.

Verification
REQ-036 Requester 1 sends 0x41, 0x42 (last on 0x42) with uart_full_i = 0 -> grant_o = 0010 one cycle after valid; uart_we_o pulses with 0x41 then 0x42; busy_o drops the next cycle.
REQ-037 Requesters 0 and 2 assert together, each sending a 2-byte message, after reset -> req 0's message completes, one IDLE cycle follows, then req 2's; bytes are not interleaved.
REQ-038 Requester 3 holds a message while uart_full_i = 1 for 20 cycles -> no req_ready_o, no uart_we_o, no timeout; the byte transfers in the first cycle after uart_full_i falls.
REQ-039 TIMEOUT = 10; requester 2 sends one non-last byte, then drops valid -> timeout_o pulses 10 idle cycles later, timeout_id_o = 2, grant moves to a pending requester 3.
REQ-040 rst_i pulsed while requester 1 is locked mid-message -> all outputs zero asynchronously; after release with requesters 1 and 0 pending, requester 0 is granted first.
REQ-041 All four requesters request continuously with 1-byte messages -> grant order 0, 1, 2, 3, 0, ...; one byte every 2 cycles.
